// File: rtl/or_gate_pkg.sv
// Shared constants and helpers for the monitored OR primitive.
// The saturating-increment helper works on a fixed maximum width; callers size-cast in and out.
package or_gate_pkg;

  localparam int OR_WIDTH_DEF = 1;
  localparam int OR_CNT_W_DEF = 16;
  localparam int OR_CNT_W_MAX = 32;

  function automatic logic [OR_CNT_W_MAX-1:0] sat_inc(
    input logic [OR_CNT_W_MAX-1:0] cnt,
    input logic [OR_CNT_W_MAX-1:0] maxVal
  );
    if (cnt >= maxVal) begin
      return maxVal;
    end
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/or_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over an increment.
// WIDTH must not exceed OR_CNT_W_MAX.
module or_sat_counter
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_CNT = '1;

  logic [WIDTH-1:0]        cnt_q;
  logic [WIDTH-1:0]        cnt_d;
  logic [OR_CNT_W_MAX-1:0] incWide;

  always_comb begin
    incWide = sat_inc(OR_CNT_W_MAX'(cnt_q), OR_CNT_W_MAX'(MAX_CNT));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = WIDTH'(incWide);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX_CNT);

endmodule

// File: rtl/or_gate.sv
// Bitwise OR with a live combinational result plus registered copy,
// reduction flag and saturating count of clock edges seen with any output bit high.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH_DEF,
  parameter int CNT_W = OR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_any,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             hi_sat
);

  logic [WIDTH-1:0] y_d;

  // y and y_any stay live through reset; only the observation state is cleared.
  assign y     = a | b;
  assign y_any = |y;
  assign y_d   = y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  or_sat_counter #(
    .WIDTH(CNT_W)
  ) u_hiCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (y_any),
    .cnt  (hi_cnt),
    .sat  (hi_sat)
  );

endmodule

// File: tb/tb_or_gate.sv
// Directed checks for truth table, latency, async reset and saturation, then a
// randomized phase where a driver queues expectations and a monitor checks them.
module tb_or_gate;

  localparam int C1 = 16;
  localparam int W4 = 4;
  localparam int C4 = 3;
  localparam int N_RAND = 300;
  localparam int MAX1 = (1 << C1) - 1;
  localparam int MAX4 = (1 << C4) - 1;

  logic clk = 1'b0;
  logic clkEn = 1'b1;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic a1 = 1'b0, b1 = 1'b0;
  logic y1, yq1, yAny1, sat1;
  logic [C1-1:0] cnt1;

  logic [W4-1:0] a4 = '0, b4 = '0;
  logic [W4-1:0] y4, yq4;
  logic yAny4, sat4;
  logic [C4-1:0] cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int y1, yAny1, yq1, cnt1, sat1;
    int y4, yAny4, yq4, cnt4, sat4;
  } exp_t;

  exp_t expQ[$];

  always #5 if (clkEn) clk = ~clk;

  or_gate #(.WIDTH(1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr),
    .y(y1), .y_q(yq1), .y_any(yAny1), .hi_cnt(cnt1), .hi_sat(sat1)
  );

  or_gate #(.WIDTH(W4), .CNT_W(C4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr),
    .y(y4), .y_q(yq4), .y_any(yAny4), .hi_cnt(cnt4), .hi_sat(sat4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random inputs: clear is rare so the wide counter climbs; zero operands are common enough to pause it.
  task automatic applyStimulus();
    clr = ($urandom_range(0, 15) == 0);
    a1 = ($urandom_range(0, 2) != 0);
    b1 = 1'(($urandom_range(0, 3) == 0));
    if ($urandom_range(0, 3) == 0) begin
      a4 = '0;
      b4 = '0;
    end else begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] ab;
    int prevY1, prevY4, prevClr, mCnt1, mCnt4, mYq1, mYq4;
    exp_t e;

    #1;
    checkOutput("reset yq1", yq1, 0);
    checkOutput("reset cnt1", cnt1, 0);
    checkOutput("reset sat1", sat1, 0);
    checkOutput("reset cnt4", cnt4, 0);
    checkOutput("reset sat4", sat4, 0);

    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #1;
      checkOutput("truth y", y1, (i != 0) ? 1 : 0);
      checkOutput("truth y_any", yAny1, (i != 0) ? 1 : 0);
      #9;
    end

    a4 = 4'b1010; b4 = 4'b0100;
    #1;
    checkOutput("w4 y", y4, 4'b1110);
    checkOutput("w4 y_any", yAny4, 1);
    a4 = '0; b4 = '0;
    #1;
    checkOutput("w4 y zero", y4, 0);
    checkOutput("w4 y_any zero", yAny4, 0);

    @(negedge clk);
    rst_n = 1'b1; a1 = 0; b1 = 0; clr = 0;

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    #1;
    checkOutput("latency y now", y1, 1);
    checkOutput("latency yq before edge", yq1, 0);
    @(posedge clk);
    #1;
    checkOutput("latency yq after edge", yq1, 1);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr start cnt1", cnt1, 0);
    repeat (5) @(negedge clk);
    checkOutput("count 5 high", cnt1, 5);
    a1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("count hold 3 low", cnt1, 5);
    a1 = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr beats inc", cnt1, 0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; a4 = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        checkOutput("sat cnt4 at 6", cnt4, 6);
        checkOutput("sat flag at 6", sat4, 0);
      end
    end
    checkOutput("sat cnt4 at 10", cnt4, 7);
    checkOutput("sat flag at 10", sat4, 1);

    clkEn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst yq1", yq1, 0);
    checkOutput("async rst cnt1", cnt1, 0);
    checkOutput("async rst y live", y1, 1);
    checkOutput("async rst yq4", yq4, 0);
    checkOutput("async rst cnt4", cnt4, 0);
    checkOutput("async rst sat4", sat4, 0);
    #20;
    checkOutput("async rst hold cnt1", cnt1, 0);
    clkEn = 1'b1;

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; a1 = 0; b1 = 0; a4 = '0; b4 = '0; clr = 0;
    prevY1 = 0; prevY4 = 0; prevClr = 0;
    mCnt1 = 0; mCnt4 = 0; mYq1 = 0; mYq4 = 0;

    fork
      begin
        for (int k = 0; k < N_RAND; k++) begin
          @(negedge clk);
          mYq1 = prevY1;
          mYq4 = prevY4;
          if (prevClr != 0) begin
            mCnt1 = 0;
            mCnt4 = 0;
          end else begin
            if (prevY1 != 0 && mCnt1 < MAX1) mCnt1 = mCnt1 + 1;
            if (prevY4 != 0 && mCnt4 < MAX4) mCnt4 = mCnt4 + 1;
          end
          applyStimulus();
          e.y1 = int'(a1 | b1);
          e.yAny1 = (e.y1 != 0) ? 1 : 0;
          e.yq1 = mYq1;
          e.cnt1 = mCnt1;
          e.sat1 = (mCnt1 == MAX1) ? 1 : 0;
          e.y4 = int'(a4 | b4);
          e.yAny4 = (e.y4 != 0) ? 1 : 0;
          e.yq4 = mYq4;
          e.cnt4 = mCnt4;
          e.sat4 = (mCnt4 == MAX4) ? 1 : 0;
          expQ.push_back(e);
          prevY1 = e.y1;
          prevY4 = e.y4;
          prevClr = int'(clr);
        end
      end
      begin
        exp_t g;
        for (int k = 0; k < N_RAND; k++) begin
          @(negedge clk);
          #1;
          if (expQ.size() == 0) begin
            checkOutput("scoreboard empty", 32'd0, 32'd1);
          end else begin
            g = expQ.pop_front();
            checkOutput("rand y1", y1, g.y1);
            checkOutput("rand y_any1", yAny1, g.yAny1);
            checkOutput("rand yq1", yq1, g.yq1);
            checkOutput("rand cnt1", cnt1, g.cnt1);
            checkOutput("rand sat1", sat1, g.sat1);
            checkOutput("rand y4", y4, g.y4);
            checkOutput("rand y_any4", yAny4, g.yAny4);
            checkOutput("rand yq4", yq4, g.yq4);
            checkOutput("rand cnt4", cnt4, g.cnt4);
            checkOutput("rand sat4", sat4, g.sat4);
          end
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
